// File: rtl/uart_rx_fifo.sv
// 8N1 serial byte receiver feeding a first-word-fall-through FIFO drained by valid/ready.
// Framing errors and overruns are reported through sticky flags that only rst clears.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          rx,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             sync1_q, sync1_d;
    logic             rx_s_q, rx_s_d;
    logic             rx_q, rx_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_done;
    logic             stop_bad;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             pop;
    logic             push_ok;

    // Synchronizer chain plus one extra stage so IDLE can see a genuine 1->0 edge.
    always_comb begin
        sync1_d = rx;
        rx_s_d  = sync1_q;
        rx_d    = rx_s_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_q    <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            rx_s_q  <= rx_s_d;
            rx_q    <= rx_d;
        end
    end

    // Receiver: the counter restarts at every sample point so each bit is taken mid-cell.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        rx_done   = 1'b0;
        stop_bad  = 1'b0;
        if (!ena) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_idx_d = '0;
            shift_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rx_q && !rx_s_q) begin
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d     = '0;
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                        if (rx_s_q) begin
                            rx_done = 1'b1;
                        end else begin
                            stop_bad = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle.
    always_comb begin
        pop         = (level_q != '0) && m_ready;
        push_ok     = rx_done && ((level_q < LVL_FULL) || pop);
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        frame_err_d = frame_err_q | stop_bad;
        overrun_d   = overrun_q | (rx_done & ~push_ok);
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_data    = mem_q[rd_ptr_q];
    assign m_valid   = (level_q != '0);
    assign level     = level_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial byte receiver with a small output FIFO, sitting directly upstream of the project core inside `tt_um_paolaunisa_top0`. It samples an 8N1 asynchronous line taken from a dedicated input pin, `ui_in[0]`. Each received byte goes into a first-word-fall-through FIFO. The core drains that FIFO through a valid/ready handshake. Framing errors and overruns are reported through sticky flags, which the top can route to `uo_out`.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be even and ≥ 4.
- `FIFO_DEPTH`, default 4: FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset. The top drives it with `~rst_n`.
- `ena` input, 1 bit: receiver enable, tied to the top-level `ena`.
- `rx` input, 1 bit: asynchronous serial line. Idle level is high.
- `m_data` output, 8 bits: byte at the FIFO head.
- `m_valid` output, 1 bit: FIFO is non-empty.
- `m_ready` input, 1 bit: consumer accepts the head byte.
- `level` output, $clog2(FIFO_DEPTH)+1 bits: number of entries currently stored.
- `frame_err` output, 1 bit: sticky; a stop bit was sampled low.
- `overrun` output, 1 bit: sticky; a valid byte was dropped because the FIFO was full.

## Operation

- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1. A third flop holds `rx_q`, the previous `rx_s`.
- **Receiver FSM states:** IDLE, START, DATA, STOP.
- **IDLE.** Leaves to START only on a falling edge, i.e. `rx_q`=1 and `rx_s`=0. A line held low (break) therefore never retriggers.
- **START.** Counts CLKS_PER_BIT/2 cycles, then samples `rx_s`.
  - Sample is 1: glitch. Return to IDLE with nothing recorded.
  - Sample is 0: go to DATA with the bit index at 0.
- **DATA.** Samples every CLKS_PER_BIT cycles. Bits shift in LSB-first. After bit 7, go to STOP.
- **STOP.** Samples after CLKS_PER_BIT cycles.
  - Stop bit = 1: push the byte.
  - Stop bit = 0: set `frame_err` and discard the byte.
  - In both cases, return to IDLE.
- **ena = 0.** Forces the FSM to IDLE and clears the bit counter and shift register. FIFO contents and the output handshake are unaffected.
- **FIFO.** Memory is `FIFO_DEPTH` x 8 with write and read pointers.
  - `m_data` = `mem[rd_ptr]`; `m_valid` = (`level` != 0).
  - Pop occurs when `m_valid` && `m_ready`.
  - Push is accepted if `level` < `FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overrun` is set.
  - A simultaneous push and pop leaves `level` unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **Sticky flags.** `frame_err` and `overrun` are cleared only by `rst`.
- **Reset values:**
  - FSM in IDLE.
  - Pointers, `level`, `m_valid`, `frame_err`, `overrun` = 0.
  - Memory cleared, so `m_data` = 0x00.
  - Synchronizer flops and `rx_q` = 1.
- **Reset mid-frame.** The partial byte is lost and the FIFO is emptied in the same cycle.

## Timing

- Let cycle t be the first cycle in which `rx_s`=0 after `rx`=1. This is two clocks after the pin falls.
- Start-bit sample: t + CLKS_PER_BIT/2.
- Data bit i (i = 0..7) sample: t + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample: t + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- The push is registered at the stop-sample edge. `m_valid` and `level` update in the following cycle.
- Pop is registered on the handshake edge. The next head byte, or `m_valid`=0, is visible the following cycle. There is no combinational path from `m_ready` to `m_valid`.
- Back-to-back frames: the next start edge may arrive as soon as the cycle after the stop sample. The FSM is back in IDLE by then.
- Sustained throughput is 1 byte per 10·CLKS_PER_BIT cycles.

## Test plan

All scenarios use `CLKS_PER_BIT`=16 and `FIFO_DEPTH`=4.

1. **Reset.** Hold `rst`=1 for 2 cycles with `rx`=1 → `m_valid`=0, `m_data`=0x00, `level`=0, `frame_err`=0, `overrun`=0.
2. **Single byte.** Send 0xA5 (8N1) with `m_ready`=0 → `m_valid`=1 and `m_data`=0xA5 one cycle after the stop sample, `level`=1. Pulse `m_ready` for 1 cycle → next cycle `m_valid`=0, `level`=0.
3. **Overrun.** Send 0x01..0x05 back-to-back with `m_ready`=0 → `level`=4, `overrun`=1. Draining with `m_ready`=1 yields 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then `m_valid`=0.
4. **Framing error.** Send 0x3C with the stop bit driven low, then hold the line high 20 cycles and send 0x7E → `frame_err`=1, `level`=1, `m_data`=0x7E.
5. **Glitch and break.**
   - Drive `rx` low for 4 cycles, then high → no push, `level`=0, FSM in IDLE.
   - Hold `rx` low for 300 cycles → exactly one `frame_err` and no retrigger.
6. **Mid-frame abort, then full-simultaneous.**
   - Deassert `ena` during bit 3 of a frame → no push and the FIFO keeps its earlier bytes.
   - Assert `rst` mid-frame → `level`=0 the next cycle.
   - With the FIFO full and `m_ready`=1 at the stop-sample cycle → push accepted, `overrun`=0, `level` stays 4.
